// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_cmp_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      LT = 2'd0,
      EQ = 2'd1,
      GT = 2'd2
   } result_e;

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit unsigned compare slice; exactly one output is high for any input pair.
module cmp_bit_slice (
   input  logic a_bit,
   input  logic b_bit,
   output logic lt,
   output logic eq,
   output logic gt
);

   assign lt = ~a_bit & b_bit;
   assign eq = ~(a_bit ^ b_bit);
   assign gt = a_bit & ~b_bit;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial comparator controller around a single 1-bit compare slice.
// Build option SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// SCAN  | one operand bit compared per cycle, MSB down to bit 0
// DONE  | done pulse, result registers just loaded
module serial_cmp_ctrl
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_e           state_q;
   result_e          res_q;
   result_e          res_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q;
   logic             done_q;
   logic             lt_q;
   logic             eq_q;
   logic             gt_q;

   logic             a_bit;
   logic             b_bit;
   logic             s_lt;
   logic             s_eq;
   logic             s_gt;
   logic             first_diff;
   logic             last_bit;

   assign a_bit = a_q[idx_q];
   assign b_bit = b_q[idx_q];

   cmp_bit_slice u_slice (
      .a_bit (a_bit),
      .b_bit (b_bit),
      .lt    (s_lt),
      .eq    (s_eq),
      .gt    (s_gt)
   );

   // A recorded difference is sticky; only an "equal so far" result can change.
   always_comb begin
      res_d      = res_q;
      first_diff = 1'b0;
      if (res_q == EQ) begin
         first_diff = ~s_eq;
         if (s_lt) begin
            res_d = LT;
         end else if (s_gt) begin
            res_d = GT;
         end
      end
   end

   assign last_bit = (idx_q == '0) || (EARLY_EXIT && first_diff);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= EQ;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  idx_q   <= IW'(WIDTH - 1);
                  res_q   <= EQ;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               res_q <= res_d;
               idx_q <= idx_q - IW'(1);
               if (last_bit) begin
                  lt_q    <= (res_d == LT);
                  eq_q    <= (res_d == EQ);
                  gt_q    <= (res_d == GT);
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Randomized and directed bench for serial_cmp_ctrl against an arithmetic reference model.
module tb_serial_cmp_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         lt;
   logic         eq;
   logic         gt;

   int n_checks = 0;
   int n_fail   = 0;

   serial_cmp_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .lt    (lt),
      .eq    (eq),
      .gt    (gt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from accepted start to done pulse.
   function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
      int k;
      logic [W-1:0] x;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      x = av ^ bv;
      if (x == '0) return W + 1;
      k = W - 1;
      while (x[k] == 1'b0) k--;
      return (W - k) + 1;
`else
      x = av ^ bv;
      k = 0;
      return W + 1 + k - k + ((x == x) ? 0 : 1);
`endif
   endfunction

   // One full compare starting in the current cycle; noise disturbs start/a/b after capture.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
      int lat;
      int got;
      logic e_lt, e_eq, e_gt;
      lat  = exp_lat(av, bv);
      got  = -1;
      e_lt = (av < bv);
      e_eq = (av == bv);
      e_gt = (av > bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= W + 3; c++) begin
         chk("busy", 32'(busy), 32'(c <= lat));
         if (done) begin
            if (got < 0) begin
               got = c;
               chk("lt", 32'(lt), 32'(e_lt));
               chk("eq", 32'(eq), 32'(e_eq));
               chk("gt", 32'(gt), 32'(e_gt));
            end else begin
               chk("extra_done", 32'(done), 32'(0));
            end
         end
         if (noise && c <= lat) begin
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk("done_cycle", 32'(got), 32'(lat));
      chk("hold_lt", 32'(lt), 32'(e_lt));
      chk("hold_eq", 32'(eq), 32'(e_eq));
      chk("hold_gt", 32'(gt), 32'(e_gt));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           nd;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_lt",   32'(lt),   32'(0));
      chk("rst_eq",   32'(eq),   32'(0));
      chk("rst_gt",   32'(gt),   32'(0));

      // start together with reset must be ignored
      start = 1'b1;
      a     = 8'h33;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_start_busy", 32'(busy), 32'(0));
      tick();
      chk("rst_start_done", 32'(done), 32'(0));

      run_op(8'h5A, 8'h5A, 1'b0);
      run_op(8'h80, 8'h7F, 1'b0);
      run_op(8'h12, 8'h13, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1);
      run_op(8'hFF, 8'hFE, 1'b1);

      // start held through two operations, a changed after capture
      nd = 0;
      for (int c = 0; c <= 24; c++) begin
         start = (c <= 12);
         a     = (c >= 3) ? 8'hFF : 8'h01;
         b     = 8'h00;
         tick();
         if ((c + 1) == 9) begin
            chk("hold_start_done1", 32'(done), 32'(1));
            chk("hold_start_gt1", 32'(gt), 32'(1));
         end else if ((c + 1) == 10 + exp_lat(8'hFF, 8'h00)) begin
            chk("hold_start_done2", 32'(done), 32'(1));
            chk("hold_start_gt2", 32'(gt), 32'(1));
         end else begin
            chk("hold_start_nodone", 32'(done), 32'(0));
         end
         if (done) nd++;
      end
      chk("hold_start_count", 32'(nd), 32'(2));

      // abort by reset mid-scan
      nd    = 0;
      a     = 8'h0F;
      b     = 8'hF0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (done) nd++;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_lt", 32'(lt), 32'(0));
      chk("abort_eq", 32'(eq), 32'(0));
      chk("abort_gt", 32'(gt), 32'(0));
      chk("abort_no_done", 32'(nd), 32'(0));
      run_op(8'h0F, 8'hF0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
